endstop_ctrl: RTL and testbench
===============================

// Module: endstop_ctrl
// PURPOSE
//  Supervises N_CH debounce channels (endstops/limit switches): arms/disarms the set, raises a latched
//  motion abort when an armed channel goes active, and logs every debounced edge with a timestamp into
//  a small event FIFO read by the CPU bus. Sits between the per-pin debounce instances and motion/bus logic.
// PARAMETERS
//  N_CH        4    number of debounce channels (1..8)
//  FIFO_DEPTH  4    event FIFO entries, power of 2, >=2
//  TS_W        16   timestamp counter width
// PORTS
//  clk         in   1         system clock
//  reset       in   1         asynchronous, active-high reset
//  ch_signal   in   N_CH      debounced levels from debounce instances
//  ch_stb      in   N_CH      1-cycle strobes: ch_signal[i] just changed
//  ch_hold     in   N_CH      1-cycle strobes: bounce started on channel i
//  polarity    in   N_CH      1 = channel active when high, 0 = active when low
//  arm_mask    in   N_CH      channels that may trip abort
//  arm         in   1         pulse: request ARMED
//  unlock      in   1         pulse: clear trip / disarm
//  ev_clr      in   1         pulse: flush FIFO, pending bits, ev_overflow
//  ev_pop      in   1         consume head event when ev_valid
//  abort       out  1         motion abort, registered
//  state       out  2         0 IDLE, 1 ARMED, 2 TRIPPED
//  trig_ch     out  N_CH      channels that caused the trip (latched)
//  pre_hold    out  1         registered: ch_hold & arm_mask nonzero while ARMED
//  ev_valid    out  1         FIFO non-empty
//  ev_data     out  9+TS_W    {ch_idx[7:0], level, timestamp[TS_W-1:0]} at FIFO head
//  ev_overflow out  1         sticky: an event was lost
// BEHAVIOUR
//  Reset: state=IDLE, abort=0, trig_ch=0, pre_hold=0, FIFO empty, ev_valid=0, ev_data=0, ev_overflow=0,
//   timestamp=0, all pending bits 0. Reset mid-operation discards queued events.
//  active[i] = (ch_signal[i] == polarity[i]); hit[i] = ch_stb[i] & arm_mask[i] & active[i].
//  IDLE: arm -> if |(active & arm_mask) then TRIPPED, trig_ch=active&arm_mask; else ARMED.
//  ARMED: |hit -> TRIPPED, trig_ch=hit (all simultaneous hits). unlock -> IDLE.
//  TRIPPED: abort=1; arm ignored; unlock -> IDLE, trig_ch=0, abort=0.
//  Priority: unlock over arm over hit in the same cycle; unlock in IDLE is a no-op.
//  Latency: qualifying strobe sampled at edge T -> state/abort/trig_ch updated at edge T (visible cycle T+1).
//  abort==(state==TRIPPED) at all times.
//  Timestamp: free-running TS_W counter, +1 per clk, wraps to 0.
//  Event capture (all channels, any state, arm_mask ignored): ch_stb[i] at edge T sets pend[i] and stores
//   lvl[i]=ch_signal[i], ts[i]=timestamp value at T. If pend[i] already set -> event dropped,
//   ev_overflow=1, stored lvl/ts kept.
//  Push: each cycle the lowest-index pending channel is written to FIFO and its pend cleared, if FIFO not
//   full or ev_pop&ev_valid this cycle; otherwise it stays pending (no loss). Earliest ev_valid: T+2.
//  Pop: ev_valid & ev_pop removes head; ev_pop when empty ignored. Push and pop in the same cycle allowed
//   at any occupancy. Pointers wrap mod FIFO_DEPTH; count width log2(FIFO_DEPTH)+1.
//  ev_clr: empties FIFO, clears pend and ev_overflow; a ch_stb in the same cycle is also discarded.
//   ev_clr does not affect state/abort.
//  ev_data valid only when ev_valid; it holds the head entry.
// TESTING
//  1 arm_mask=0001, polarity=0001, arm, later ch_signal[0]=1 with ch_stb[0] -> state=2, abort=1 next cycle,
//    trig_ch=0001; unlock -> state=0, abort=0, trig_ch=0.
//  2 ch_signal[1] active, arm_mask=0010, arm -> immediate TRIPPED, trig_ch=0010; arm+unlock same cycle
//    from ARMED -> IDLE.
//  3 ch_stb on ch2 and ch0 same cycle at ts=0x0010 -> two events popped in order ch0 then ch2,
//    both timestamp 0x0010.
//  4 6 strobes on distinct cycles/channels, no pops, depth 4 -> 4 queued, rest pending; a second stb on a
//    pending channel sets ev_overflow; pops drain remaining in index order.
//  5 Timestamp wrap: event just before and after 0xFFFF -> ts 0xFFFF then 0x0000.
//  6 Assert reset while TRIPPED with 3 queued events -> abort=0, state=0, ev_valid=0, ev_overflow=0
//    immediately (asynchronous).

Source files
------------

// File: rtl/endstop_ctrl.sv
// Endstop supervisor: arm/trip FSM driving a latched motion abort, plus timestamped
// edge logging of all debounce channels into a small event FIFO.
module endstop_ctrl #(
  parameter int N_CH       = 4,
  parameter int FIFO_DEPTH = 4,
  parameter int TS_W       = 16
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [N_CH-1:0]   ch_signal,
  input  logic [N_CH-1:0]   ch_stb,
  input  logic [N_CH-1:0]   ch_hold,
  input  logic [N_CH-1:0]   polarity,
  input  logic [N_CH-1:0]   arm_mask,
  input  logic              arm,
  input  logic              unlock,
  input  logic              ev_clr,
  input  logic              ev_pop,
  output logic              abort,
  output logic [1:0]        state,
  output logic [N_CH-1:0]   trig_ch,
  output logic              pre_hold,
  output logic              ev_valid,
  output logic [9+TS_W-1:0] ev_data,
  output logic              ev_overflow
);
  localparam int PW = $clog2(FIFO_DEPTH);
  localparam int CW = PW + 1;
  localparam int EW = 9 + TS_W;

  typedef enum logic [1:0] {IDLE = 2'd0, ARMED = 2'd1, TRIPPED = 2'd2} state_t;

  state_t            st;
  logic [N_CH-1:0]   active, arm_act, hit;
  logic [TS_W-1:0]   ts_cnt;
  logic [N_CH-1:0]   pend, lvl;
  logic [TS_W-1:0]   ts_st [N_CH];
  logic [EW-1:0]     mem [FIFO_DEPTH];
  logic [PW-1:0]     wr_ptr, rd_ptr;
  logic [CW-1:0]     count;
  logic              any_pend, full, do_push, do_pop;
  logic [N_CH-1:0]   sel_oh;
  logic [7:0]        sel_idx;
  logic              push_lvl;
  logic [TS_W-1:0]   push_ts;

  assign active  = ~(ch_signal ^ polarity);
  assign arm_act = active & arm_mask;
  assign hit     = ch_stb & arm_act;
  assign state   = st;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      st       <= IDLE;
      abort    <= 1'b0;
      trig_ch  <= '0;
      pre_hold <= 1'b0;
    end else begin
      pre_hold <= (st == ARMED) && (|(ch_hold & arm_mask));
      case (st)
        IDLE:
          if (!unlock && arm) begin
            if (|arm_act) begin
              st      <= TRIPPED;
              trig_ch <= arm_act;
              abort   <= 1'b1;
            end else begin
              st <= ARMED;
            end
          end
        ARMED:
          if (unlock) begin
            st <= IDLE;
          end else if (|hit) begin
            st      <= TRIPPED;
            trig_ch <= hit;
            abort   <= 1'b1;
          end
        TRIPPED:
          if (unlock) begin
            st      <= IDLE;
            trig_ch <= '0;
            abort   <= 1'b0;
          end
        default: begin
          st      <= IDLE;
          trig_ch <= '0;
          abort   <= 1'b0;
        end
      endcase
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) ts_cnt <= '0;
    else       ts_cnt <= ts_cnt + TS_W'(1);
  end

  // Lowest-index pending channel wins the single FIFO write slot each cycle.
  always_comb begin
    any_pend = 1'b0;
    sel_oh   = '0;
    sel_idx  = '0;
    push_lvl = 1'b0;
    push_ts  = '0;
    for (int unsigned i = 0; i < N_CH; i++) begin
      if (pend[i] && !any_pend) begin
        any_pend  = 1'b1;
        sel_oh[i] = 1'b1;
        sel_idx   = 8'(i);
        push_lvl  = lvl[i];
        push_ts   = ts_st[i];
      end
    end
  end

  assign full    = (count == CW'(FIFO_DEPTH));
  assign ev_valid = (count != '0);
  assign do_pop  = ev_pop && ev_valid && !ev_clr;
  assign do_push = any_pend && (!full || do_pop) && !ev_clr;
  assign ev_data = ev_valid ? mem[rd_ptr] : '0;

  // Push clears only a set pend bit and capture only sets a clear one, so both never collide.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      pend        <= '0;
      lvl         <= '0;
      ev_overflow <= 1'b0;
      for (int unsigned i = 0; i < N_CH; i++) ts_st[i] <= '0;
    end else if (ev_clr) begin
      pend        <= '0;
      ev_overflow <= 1'b0;
    end else begin
      for (int unsigned i = 0; i < N_CH; i++) begin
        if (do_push && sel_oh[i]) pend[i] <= 1'b0;
        if (ch_stb[i]) begin
          if (pend[i]) begin
            ev_overflow <= 1'b1;
          end else begin
            pend[i]  <= 1'b1;
            lvl[i]   <= ch_signal[i];
            ts_st[i] <= ts_cnt;
          end
        end
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
      for (int unsigned i = 0; i < FIFO_DEPTH; i++) mem[i] <= '0;
    end else if (ev_clr) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) begin
        mem[wr_ptr] <= {sel_idx, push_lvl, push_ts};
        wr_ptr      <= wr_ptr + PW'(1);
      end
      if (do_pop) rd_ptr <= rd_ptr + PW'(1);
      case ({do_push, do_pop})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
    end
  end
endmodule

// File: tb/tb_endstop_ctrl.sv
// Scoreboard bench for endstop_ctrl: stimulus queues expected events, a negedge
// monitor compares each popped FIFO head; FSM outputs are checked directly.
module tb_endstop_ctrl;
  logic        clk = 1'b0;
  logic        reset;
  logic [3:0]  ch_signal, ch_stb, ch_hold, polarity, arm_mask;
  logic        arm, unlock, ev_clr, ev_pop;
  logic        abort, pre_hold, ev_valid, ev_overflow;
  logic [1:0]  state;
  logic [3:0]  trig_ch;
  logic [24:0] ev_data;

  logic [15:0] tb_ts;
  logic [24:0] exp_q [$];
  int          n_checks = 0;
  int          n_fail   = 0;

  endstop_ctrl #(.N_CH(4), .FIFO_DEPTH(4), .TS_W(16)) dut (
    .clk(clk), .reset(reset), .ch_signal(ch_signal), .ch_stb(ch_stb), .ch_hold(ch_hold),
    .polarity(polarity), .arm_mask(arm_mask), .arm(arm), .unlock(unlock), .ev_clr(ev_clr),
    .ev_pop(ev_pop), .abort(abort), .state(state), .trig_ch(trig_ch), .pre_hold(pre_hold),
    .ev_valid(ev_valid), .ev_data(ev_data), .ev_overflow(ev_overflow)
  );

  always #5 clk = ~clk;

  // Reference timestamp: value the DUT will sample at the next edge.
  always @(posedge clk or posedge reset) begin
    if (reset) tb_ts <= 16'h0000;
    else       tb_ts <= tb_ts + 16'h0001;
  end

  function automatic logic [24:0] mk(input int ch, input logic lv, input logic [15:0] ts);
    logic [31:0] c;
    c = ch;
    return {c[7:0], lv, ts};
  endfunction

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, got, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic cycn(input int n);
    for (int k = 0; k < n; k++) cyc();
  endtask

  always @(negedge clk) begin
    if (!reset && ev_valid && ev_pop) begin
      n_checks++;
      if (exp_q.size() == 0) begin
        n_fail++;
        $display("FAIL ev_unexpected: got %0h expected no event", ev_data);
      end else begin
        logic [24:0] e;
        e = exp_q.pop_front();
        if (ev_data !== e) begin
          n_fail++;
          $display("FAIL ev_data: got %0h expected %0h", ev_data, e);
        end
      end
    end
  end

  initial begin
    reset = 1'b1;
    ch_signal = '0; ch_stb = '0; ch_hold = '0; polarity = '0; arm_mask = '0;
    arm = 1'b0; unlock = 1'b0; ev_clr = 1'b0; ev_pop = 1'b0;
    cycn(3);
    check("rst_state", 32'(state), 0);
    check("rst_abort", 32'(abort), 0);
    check("rst_trig", 32'(trig_ch), 0);
    check("rst_pre_hold", 32'(pre_hold), 0);
    check("rst_ev_valid", 32'(ev_valid), 0);
    check("rst_ev_data", 32'(ev_data), 0);
    check("rst_overflow", 32'(ev_overflow), 0);
    reset = 1'b0;

    // Simultaneous strobes on ch2 and ch0 at timestamp 0x0010
    for (int k = 0; k < 100 && tb_ts != 16'h0010; k++) cyc();
    check("t3_ts_reach", 32'(tb_ts), 32'h10);
    ch_signal = 4'b0100;
    ch_stb    = 4'b0101;
    exp_q.push_back(mk(0, 1'b0, 16'h0010));
    exp_q.push_back(mk(2, 1'b1, 16'h0010));
    cyc();
    ch_stb = '0;
    check("t3_valid_latency", 32'(ev_valid), 0);
    cyc();
    check("t3_valid_t2", 32'(ev_valid), 1);
    ev_pop = 1'b1;
    cycn(4);
    ev_pop = 1'b0;
    check("t3_drained", 32'(ev_valid), 0);

    // Arm, pre-hold, strobe trip, arm ignored while tripped, unlock
    ch_signal = 4'b0000; polarity = 4'b0001; arm_mask = 4'b0001;
    arm = 1'b1; cyc(); arm = 1'b0;
    check("t1_armed", 32'(state), 1);
    check("t1_abort_armed", 32'(abort), 0);
    ch_hold = 4'b0001; cyc(); ch_hold = '0;
    check("t1_pre_hold", 32'(pre_hold), 1);
    cyc();
    check("t1_pre_hold_off", 32'(pre_hold), 0);
    ch_signal = 4'b0001; ch_stb = 4'b0001;
    exp_q.push_back(mk(0, 1'b1, tb_ts));
    cyc(); ch_stb = '0;
    check("t1_tripped", 32'(state), 2);
    check("t1_abort", 32'(abort), 1);
    check("t1_trig", 32'(trig_ch), 32'h1);
    arm = 1'b1; cyc(); arm = 1'b0;
    check("t1_arm_ignored", 32'(state), 2);
    unlock = 1'b1; cyc(); unlock = 1'b0;
    check("t1_unlock_state", 32'(state), 0);
    check("t1_unlock_abort", 32'(abort), 0);
    check("t1_unlock_trig", 32'(trig_ch), 0);
    ev_pop = 1'b1; cycn(3); ev_pop = 1'b0;

    // Immediate trip on arm; arm+unlock from ARMED
    polarity = 4'b0011; ch_signal = 4'b0010; arm_mask = 4'b0010;
    arm = 1'b1; cyc(); arm = 1'b0;
    check("t2_imm_trip", 32'(state), 2);
    check("t2_imm_trig", 32'(trig_ch), 32'h2);
    check("t2_imm_abort", 32'(abort), 1);
    unlock = 1'b1; cyc(); unlock = 1'b0;
    check("t2_unlock", 32'(state), 0);
    ch_signal = 4'b0000;
    arm = 1'b1; cyc(); arm = 1'b0;
    check("t2_armed", 32'(state), 1);
    arm = 1'b1; unlock = 1'b1; cyc(); arm = 1'b0; unlock = 1'b0;
    check("t2_unlock_over_arm", 32'(state), 0);
    unlock = 1'b1; cyc(); unlock = 1'b0;
    check("t2_unlock_idle_noop", 32'(state), 0);

    // FIFO fill, pending backlog, overflow, ordered drain
    arm_mask = '0;
    ev_clr = 1'b1; cyc(); ev_clr = 1'b0;
    begin
      int chs [7] = '{0, 1, 2, 3, 0, 1, 0};
      for (int k = 0; k < 7; k++) begin
        ch_signal[chs[k]] = ~ch_signal[chs[k]];
        ch_stb = 4'(1 << chs[k]);
        if (k != 6) exp_q.push_back(mk(chs[k], ch_signal[chs[k]], tb_ts));
        cyc();
        ch_stb = '0;
      end
    end
    cyc();
    check("t4_overflow", 32'(ev_overflow), 1);
    check("t4_valid", 32'(ev_valid), 1);
    ev_pop = 1'b1; cycn(10); ev_pop = 1'b0;
    check("t4_queue_empty", 32'(exp_q.size()), 0);
    check("t4_fifo_empty", 32'(ev_valid), 0);
    ch_stb = 4'b0001; ev_clr = 1'b1; cyc(); ch_stb = '0; ev_clr = 1'b0;
    check("clr_overflow", 32'(ev_overflow), 0);
    check("clr_valid", 32'(ev_valid), 0);
    cycn(3);
    check("clr_stb_discarded", 32'(ev_valid), 0);

    // Timestamp wrap
    for (int k = 0; k < 70000 && tb_ts != 16'hFFFF; k++) cyc();
    check("t5_ts_reach", 32'(tb_ts), 32'hFFFF);
    ch_signal = 4'b1010;
    ch_stb = 4'b0010;
    exp_q.push_back(mk(1, 1'b1, 16'hFFFF));
    cyc();
    ch_stb = 4'b1000;
    exp_q.push_back(mk(3, 1'b1, 16'h0000));
    cyc();
    ch_stb = '0;
    cyc();
    ev_pop = 1'b1; cycn(4); ev_pop = 1'b0;
    check("t5_queue_empty", 32'(exp_q.size()), 0);

    // Asynchronous reset while tripped with queued events and overflow
    polarity = 4'b0001; arm_mask = 4'b0001; ch_signal = 4'b0001;
    arm = 1'b1; cyc(); arm = 1'b0;
    check("t6_tripped", 32'(state), 2);
    ch_stb = 4'b0001; exp_q.push_back(mk(0, 1'b1, tb_ts)); cyc();
    ch_stb = 4'b0001; cyc();
    ch_stb = 4'b0010; exp_q.push_back(mk(1, 1'b0, tb_ts)); cyc();
    ch_stb = 4'b0100; exp_q.push_back(mk(2, 1'b0, tb_ts)); cyc();
    ch_stb = '0;
    cycn(2);
    check("t6_pre_overflow", 32'(ev_overflow), 1);
    check("t6_pre_valid", 32'(ev_valid), 1);
    check("t6_pre_abort", 32'(abort), 1);
    @(posedge clk);
    #3;
    reset = 1'b1;
    #1;
    check("t6_abort", 32'(abort), 0);
    check("t6_state", 32'(state), 0);
    check("t6_valid", 32'(ev_valid), 0);
    check("t6_overflow", 32'(ev_overflow), 0);
    check("t6_trig", 32'(trig_ch), 0);
    exp_q.delete();
    cycn(2);
    reset = 1'b0;
    cycn(2);
    check("t6_post_valid", 32'(ev_valid), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
